data_memory_sized: RTL and testbench
====================================

# data_memory_sized

Parametrised successor to the MIPS datapath's byte-addressed data memory. Supports byte, halfword and word accesses with sign or zero extension for loads (lb/lbu/lh/lhu/lw/sb/sh/sw) and a configurable power-of-two depth. A configurable wait-state count sits behind a Ready/Done handshake, and misaligned or illegal requests are flagged. It sits in the MEM stage; the pipeline stalls on Ready=0. Storage is big-endian: byte at Address holds bits [31:24] of a word.

## Interface
- DEPTH_LOG2, default 16: memory holds 2^DEPTH_LOG2 bytes; higher address bits are ignored (modulo wrap).
- LATENCY, default 0: wait states per access, 0..15.

- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high.
- MemoryRead  in  1  load request.
- MemoryWrite  in  1  store request.
- Size  in  2  access size: 00 byte, 01 half, 10 word, 11 reserved.
- Unsigned  in  1  load zero-extends when 1, sign-extends when 0.
- Address  in  32  byte address.
- InputData  in  32  store data, right-justified (byte in [7:0], half in [15:0]).
- OutputData  out  32  load result, extended to 32 bits.
- Ready  out  1  block can accept a request this cycle.
- Done  out  1  one-cycle pulse: access completed or rejected.
- Error  out  1  qualifies Done: request was rejected.

## Operation
- A request is accepted at a rising edge where Ready=1 and (MemoryRead|MemoryWrite)=1.
- At acceptance, Size, Unsigned, Address[DEPTH_LOG2-1:0], InputData and the operation are captured. Inputs may change afterwards.
- The request is rejected (Error=1 with Done, no memory change, OutputData=0) in any of these cases:
  - MemoryRead and MemoryWrite are both 1.
  - Size=11.
  - Size=01 with Address[0]=1.
  - Size=10 with Address[1:0]≠00.
- Rejection follows the same latency as a legal access.
- Write: only the addressed bytes change.
  - Byte writes InputData[7:0] to A.
  - Half writes [15:8] to A and [7:0] to A+1.
  - Word is big-endian over A..A+3.
- Read returns the addressed bytes extended per Unsigned. Example: byte 0x80 gives 0xFFFFFF80 when signed and 0x00000080 when unsigned.
- Addresses wrap modulo 2^DEPTH_LOG2. An aligned access never straddles the top.
- State machine:
  - IDLE (Ready=1): on accept, go to WAIT if LATENCY>0, else perform the access and stay in IDLE.
  - WAIT (Ready=0): counter loads LATENCY-1 and decrements each cycle. At 0, perform the access and go to IDLE.
- Reset: Ready=1, Done=0, Error=0, OutputData=0, state IDLE, counter 0. Memory contents are not cleared.
- Reset mid-WAIT: the pending access is discarded; a pending store never reaches memory.

## Timing
- LATENCY=0, request accepted at edge k:
  - The access is performed at edge k.
  - Done, Error and OutputData are valid in the cycle after edge k.
  - Ready stays 1, so back-to-back accesses run one per cycle.
- LATENCY=N>0, request accepted at edge k:
  - Ready=0 from edge k to edge k+N.
  - The access is performed at edge k+N.
  - Done=1 in the cycle after edge k+N, and Ready returns to 1 in that same cycle.
  - Throughput is one access per N+1 cycles.
- OutputData holds its value until the next completed read or rejection. A completed write does not change it.
- Done is never 1 for two consecutive cycles unless two requests completed on consecutive edges.
- Requests are ignored while Ready=0.

## Structure
- Package dmem_pkg holds:
  - Size encodings SIZE_BYTE/SIZE_HALF/SIZE_WORD/SIZE_RSVD.
  - State enum IDLE/WAIT.
  - A function is_misaligned(size, addr[1:0]).
- Sub-module dmem_lane_align (combinational) holds the load-side lane select and the sign/zero extension.
- Storage and the state machine live in the top module.

## Test plan
- LATENCY=0: sw 0x11223344 at 0x100, then lw 0x100 → 0x11223344. Then lbu 0x101 → 0x00000022 and lh 0x102 → 0x00003344, one access per cycle with Ready held at 1.
- sb 0x80 at 0x203, then lb 0x203 → 0xFFFFFF80 and lbu → 0x00000080. Bytes 0x200–0x202 are unchanged (read back by lw).
- Misaligned sh at 0x101, lw at 0x102, and Size=11 → each gives Done=1, Error=1, OutputData=0, and the target memory is unchanged.
- LATENCY=3: lw accepted at edge k → Ready=0 for 3 cycles and Done at cycle k+4. A request presented during the wait is ignored.
- LATENCY=3: sw issued, then reset asserted in the second wait cycle → Ready=1, Done=0 immediately. A later lw shows the old data.
- DEPTH_LOG2=8: sw to 0x104, then lw 0x004 → same data (wrap).

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared encodings for the sized data memory: access sizes, FSM states, the captured request
// and the alignment rule.
package dmem_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10,
        SIZE_RSVD = 2'b11
    } size_e;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_e;

    typedef struct packed {
        logic        rd;
        logic        wr;
        logic        err;
        size_e       size;
        logic        uns;
        logic [31:0] wdat;
    } req_t;

    localparam int CNT_W = 4;

    function automatic logic is_misaligned(input size_e size, input logic [1:0] addr);
        case (size)
            SIZE_HALF: is_misaligned = addr[0];
            SIZE_WORD: is_misaligned = |addr;
            default:   is_misaligned = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_if.sv
// Request/response bundle between the MEM stage and the data memory.
// The master drives requests; the slave answers with Ready/Done/Error and load data.
interface dmem_if;
    logic        MemoryRead;
    logic        MemoryWrite;
    logic [1:0]  Size;
    logic        Unsigned;
    logic [31:0] Address;
    logic [31:0] InputData;
    logic [31:0] OutputData;
    logic        Ready;
    logic        Done;
    logic        Error;

    modport master (
        output MemoryRead, MemoryWrite, Size, Unsigned, Address, InputData,
        input  OutputData, Ready, Done, Error
    );

    modport slave (
        input  MemoryRead, MemoryWrite, Size, Unsigned, Address, InputData,
        output OutputData, Ready, Done, Error
    );
endinterface

// File: rtl/dmem_lane_align.sv
// Picks the addressed byte/half out of a big-endian word and sign/zero extends it.
// Purely combinational, no backpressure.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [31:0] word_dat,
    input  size_e       size,
    input  logic        uns,
    input  logic [1:0]  offset,
    output logic [31:0] load_dat
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = 8'h00;
        half_sel = 16'h0000;
        load_dat = 32'h0000_0000;

        // Offset 0 is the most significant lane.
        case (offset)
            2'd0:    byte_sel = word_dat[31:24];
            2'd1:    byte_sel = word_dat[23:16];
            2'd2:    byte_sel = word_dat[15:8];
            default: byte_sel = word_dat[7:0];
        endcase
        half_sel = offset[1] ? word_dat[15:0] : word_dat[31:16];

        case (size)
            SIZE_BYTE: load_dat = {{24{~uns & byte_sel[7]}}, byte_sel};
            SIZE_HALF: load_dat = {{16{~uns & half_sel[15]}}, half_sel};
            default:   load_dat = word_dat;
        endcase
    end

endmodule

// File: rtl/data_memory_sized.sv
// Byte-addressed big-endian data memory with byte/half/word access, latency 0..15 wait states.
// Ready drops for the wait states; requests presented while Ready=0 are ignored.
module data_memory_sized
    import dmem_pkg::*;
#(
    parameter int DEPTH_LOG2 = 16,
    parameter int LATENCY    = 0
) (
    input  logic  clock,
    input  logic  reset,
    dmem_if.slave bus
);

    localparam int              WORDS    = 2 ** (DEPTH_LOG2 - 2);
    localparam logic [CNT_W-1:0] CNT_INIT = (LATENCY > 0) ? CNT_W'(LATENCY - 1) : '0;

    logic [31:0] mem [WORDS];

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    req_t                  req_q, req_d;
    logic [DEPTH_LOG2-1:0] addr_q, addr_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;
    logic [31:0]           rdat_q, rdat_d;

    req_t                  cur_req, exe_req;
    logic [DEPTH_LOG2-1:0] exe_addr;
    logic                  accept, exe_vld, wr_en;
    logic [3:0]            be;
    logic [31:0]           wr_word, rd_word, load_dat;
    logic                  unused_addr_hi;

    // Depth is a power of two, so dropping the upper bits gives the modulo wrap.
    assign unused_addr_hi = ^bus.Address[31:DEPTH_LOG2];

    always_comb begin
        cur_req      = '0;
        cur_req.rd   = bus.MemoryRead;
        cur_req.wr   = bus.MemoryWrite;
        cur_req.size = size_e'(bus.Size);
        cur_req.uns  = bus.Unsigned;
        cur_req.wdat = bus.InputData;
        cur_req.err  = (bus.MemoryRead & bus.MemoryWrite)
                     | (cur_req.size == SIZE_RSVD)
                     | is_misaligned(cur_req.size, bus.Address[1:0]);
    end

    // In IDLE the live request executes directly (zero latency); in WAIT the captured one does.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        req_d    = req_q;
        addr_d   = addr_q;
        accept   = 1'b0;
        exe_vld  = 1'b0;
        exe_req  = req_q;
        exe_addr = addr_q;

        case (state_q)
            IDLE: begin
                accept   = cur_req.rd | cur_req.wr;
                exe_req  = cur_req;
                exe_addr = bus.Address[DEPTH_LOG2-1:0];
                if (accept) begin
                    if (LATENCY == 0) begin
                        exe_vld = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_INIT;
                        req_d   = cur_req;
                        addr_d  = bus.Address[DEPTH_LOG2-1:0];
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    exe_vld = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // be[j] enables word bits [8j+7:8j]; lane at offset 0 is be[3].
    always_comb begin
        be      = 4'b0000;
        wr_word = exe_req.wdat;
        case (exe_req.size)
            SIZE_BYTE: begin
                be      = 4'b1000 >> exe_addr[1:0];
                wr_word = {4{exe_req.wdat[7:0]}};
            end
            SIZE_HALF: begin
                be      = 4'b1100 >> exe_addr[1:0];
                wr_word = {2{exe_req.wdat[15:0]}};
            end
            SIZE_WORD: be = 4'b1111;
            default:   be = 4'b0000;
        endcase
        wr_en = exe_vld & exe_req.wr & ~exe_req.err & ~reset;
    end

    assign rd_word = mem[exe_addr[DEPTH_LOG2-1:2]];

    dmem_lane_align u_align (
        .word_dat (rd_word),
        .size     (exe_req.size),
        .uns      (exe_req.uns),
        .offset   (exe_addr[1:0]),
        .load_dat (load_dat)
    );

    always_comb begin
        done_d  = exe_vld;
        error_d = exe_vld & exe_req.err;
        rdat_d  = rdat_q;
        if (exe_vld) begin
            if (exe_req.err) begin
                rdat_d = 32'h0000_0000;
            end else if (exe_req.rd) begin
                rdat_d = load_dat;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (wr_en) begin
            for (int j = 0; j < 4; j++) begin
                if (be[j]) begin
                    mem[exe_addr[DEPTH_LOG2-1:2]][8*j +: 8] <= wr_word[8*j +: 8];
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            req_q   <= '0;
            addr_q  <= '0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            rdat_q  <= 32'h0000_0000;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            done_q  <= done_d;
            error_q <= error_d;
            rdat_q  <= rdat_d;
        end
    end

    assign bus.Ready      = (state_q == IDLE);
    assign bus.Done       = done_q;
    assign bus.Error      = error_q;
    assign bus.OutputData = rdat_q;

endmodule

// File: tb/tb_data_memory_sized.sv
// Bench for data_memory_sized: three instances cover zero latency, three wait states and a
// 256-byte depth; a byte-array model predicts loads, rejections and held output data.
module tb_data_memory_sized;

    logic clk = 1'b0;
    logic rst0, rst3, rst8;
    always #5 clk = ~clk;

    dmem_if b0 ();
    dmem_if b3 ();
    dmem_if b8 ();

    data_memory_sized #(.DEPTH_LOG2(16), .LATENCY(0)) u0 (.clock(clk), .reset(rst0), .bus(b0));
    data_memory_sized #(.DEPTH_LOG2(16), .LATENCY(3)) u3 (.clock(clk), .reset(rst3), .bus(b3));
    data_memory_sized #(.DEPTH_LOG2(8),  .LATENCY(0)) u8 (.clock(clk), .reset(rst8), .bus(b8));

    int total  = 0;
    int passed = 0;

    logic [7:0]  m0 [0:65535];
    logic [31:0] exp_out0 = 32'h0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Reference: plain byte array, big-endian byte order, arithmetic extension.
    task automatic model0(input bit rd, input bit wr, input logic [1:0] sz, input bit uns,
                          input logic [31:0] a, input logic [31:0] d, output bit err);
        int          n;
        int unsigned base;
        logic [63:0] v;
        base = a % 65536;
        err  = (rd && wr) || sz == 2'd3 || (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0);
        n    = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        if (err) begin
            exp_out0 = 32'h0;
        end else if (wr) begin
            for (int i = 0; i < n; i++)
                m0[(base + i) % 65536] = 8'((d >> (8 * (n - 1 - i))) & 32'hFF);
        end else begin
            v = 64'h0;
            for (int i = 0; i < n; i++)
                v = (v << 8) | 64'(m0[(base + i) % 65536]);
            if (!uns && v[8*n-1]) v = v - (64'd1 << (8 * n));
            exp_out0 = v[31:0];
        end
    endtask

    task automatic op0(input string tag, input bit rd, input bit wr, input logic [1:0] sz,
                       input bit uns, input logic [31:0] a, input logic [31:0] d);
        bit err;
        b0.MemoryRead  = rd;
        b0.MemoryWrite = wr;
        b0.Size        = sz;
        b0.Unsigned    = uns;
        b0.Address     = a;
        b0.InputData   = d;
        @(posedge clk); #1;
        b0.MemoryRead  = 1'b0;
        b0.MemoryWrite = 1'b0;
        model0(rd, wr, sz, uns, a, d, err);
        check({tag, ".done"}, 32'(b0.Done), 1);
        check({tag, ".err"},  32'(b0.Error), 32'(err));
        check({tag, ".out"},  b0.OutputData, exp_out0);
        check({tag, ".rdy"},  32'(b0.Ready), 1);
    endtask

    task automatic op3(input string tag, input bit rd, input bit wr, input logic [1:0] sz,
                       input logic [31:0] a, input logic [31:0] d, output logic [31:0] out);
        int n;
        b3.MemoryRead  = rd;
        b3.MemoryWrite = wr;
        b3.Size        = sz;
        b3.Unsigned    = 1'b0;
        b3.Address     = a;
        b3.InputData   = d;
        @(posedge clk); #1;
        b3.MemoryRead  = 1'b0;
        b3.MemoryWrite = 1'b0;
        n = 1;
        while (b3.Done !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, ".lat"}, 32'(n), 4);
        out = b3.OutputData;
    endtask

    task automatic op8(input bit rd, input bit wr, input logic [1:0] sz, input bit uns,
                       input logic [31:0] a, input logic [31:0] d);
        b8.MemoryRead  = rd;
        b8.MemoryWrite = wr;
        b8.Size        = sz;
        b8.Unsigned    = uns;
        b8.Address     = a;
        b8.InputData   = d;
        @(posedge clk); #1;
        b8.MemoryRead  = 1'b0;
        b8.MemoryWrite = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] out;
        logic [31:0] a, d;
        logic [1:0]  sz;
        int          r;

        rst0 = 1'b1; rst3 = 1'b1; rst8 = 1'b1;
        b0.MemoryRead = 1'b0; b0.MemoryWrite = 1'b0; b0.Size = 2'd0; b0.Unsigned = 1'b0;
        b0.Address = 32'h0; b0.InputData = 32'h0;
        b3.MemoryRead = 1'b0; b3.MemoryWrite = 1'b0; b3.Size = 2'd0; b3.Unsigned = 1'b0;
        b3.Address = 32'h0; b3.InputData = 32'h0;
        b8.MemoryRead = 1'b0; b8.MemoryWrite = 1'b0; b8.Size = 2'd0; b8.Unsigned = 1'b0;
        b8.Address = 32'h0; b8.InputData = 32'h0;
        repeat (3) @(negedge clk);
        rst0 = 1'b0; rst3 = 1'b0; rst8 = 1'b0;

        check("rst.rdy0", 32'(b0.Ready), 1);
        check("rst.done0", 32'(b0.Done), 0);
        check("rst.err0", 32'(b0.Error), 0);
        check("rst.out0", b0.OutputData, 32'h0);
        check("rst.rdy3", 32'(b3.Ready), 1);
        check("rst.out3", b3.OutputData, 32'h0);
        @(posedge clk); #1;

        // Zero latency, back to back.
        op0("sw100", 0, 1, 2'd2, 0, 32'h100, 32'h11223344);
        op0("lw100", 1, 0, 2'd2, 0, 32'h100, 32'h0);
        check("lw100.const", b0.OutputData, 32'h11223344);
        op0("lbu101", 1, 0, 2'd0, 1, 32'h101, 32'h0);
        check("lbu101.const", b0.OutputData, 32'h00000022);
        op0("lh102", 1, 0, 2'd1, 0, 32'h102, 32'h0);
        check("lh102.const", b0.OutputData, 32'h00003344);

        op0("sw200", 0, 1, 2'd2, 0, 32'h200, 32'hA1B2C3D4);
        op0("sb203", 0, 1, 2'd0, 0, 32'h203, 32'hFFFF_FF80);
        check("sb203.hold", b0.OutputData, 32'h00003344);
        op0("lb203", 1, 0, 2'd0, 0, 32'h203, 32'h0);
        check("lb203.const", b0.OutputData, 32'hFFFFFF80);
        op0("lbu203", 1, 0, 2'd0, 1, 32'h203, 32'h0);
        check("lbu203.const", b0.OutputData, 32'h00000080);
        op0("lw200", 1, 0, 2'd2, 0, 32'h200, 32'h0);
        check("lw200.const", b0.OutputData, 32'hA1B2C380);

        // Rejections leave memory alone.
        op0("sh101", 0, 1, 2'd1, 0, 32'h101, 32'h0000BEEF);
        check("sh101.e", 32'(b0.Error), 1);
        op0("lw102", 1, 0, 2'd2, 0, 32'h102, 32'h0);
        op0("rsvd100", 0, 1, 2'd3, 0, 32'h100, 32'h55555555);
        op0("rdwr100", 1, 1, 2'd2, 0, 32'h100, 32'h66666666);
        op0("lw100b", 1, 0, 2'd2, 0, 32'h100, 32'h0);
        check("lw100b.const", b0.OutputData, 32'h11223344);
        @(posedge clk); #1;
        check("idle.done0", 32'(b0.Done), 0);

        // Randomised traffic in a prefilled window.
        for (int i = 0; i < 16; i++)
            op0("fill", 0, 1, 2'd2, 0, 32'h400 + 32'(4 * i), $urandom);
        for (int i = 0; i < 200; i++) begin
            r  = $urandom_range(0, 9);
            sz = 2'($urandom_range(0, 3));
            a  = 32'h400 + 32'($urandom_range(0, 63));
            if ($urandom_range(0, 3) != 0)
                a = a & ~((sz == 2'd2) ? 32'd3 : (sz == 2'd1) ? 32'd1 : 32'd0);
            if ($urandom_range(0, 1) == 1)
                a = a | {16'($urandom_range(0, 65535)), 16'h0};
            d = $urandom;
            op0("rnd", (r < 4) || (r >= 8), (r >= 4), sz, 1'($urandom_range(0, 1)), a, d);
        end

        // Three wait states; a request held during the wait is ignored.
        b3.MemoryWrite = 1'b1; b3.Size = 2'd2; b3.Address = 32'h300; b3.InputData = 32'h12345678;
        @(posedge clk); #1;
        check("l3.rdy_k", 32'(b3.Ready), 0);
        check("l3.done_k", 32'(b3.Done), 0);
        b3.InputData = 32'hDEADBEEF;
        @(posedge clk); #1;
        check("l3.rdy_k1", 32'(b3.Ready), 0);
        @(posedge clk); #1;
        check("l3.rdy_k2", 32'(b3.Ready), 0);
        check("l3.done_k2", 32'(b3.Done), 0);
        b3.MemoryWrite = 1'b0;
        @(posedge clk); #1;
        check("l3.rdy_k3", 32'(b3.Ready), 1);
        check("l3.done_k3", 32'(b3.Done), 1);
        check("l3.err_k3", 32'(b3.Error), 0);
        @(posedge clk); #1;
        check("l3.done_k4", 32'(b3.Done), 0);
        op3("l3.lw", 1, 0, 2'd2, 32'h300, 32'h0, out);
        check("l3.lw.out", out, 32'h12345678);

        // Reset during the second wait cycle drops the pending store.
        b3.MemoryWrite = 1'b1; b3.Size = 2'd2; b3.Address = 32'h300; b3.InputData = 32'hCAFEF00D;
        @(posedge clk); #1;
        b3.MemoryWrite = 1'b0;
        @(posedge clk); #1;
        rst3 = 1'b1;
        #1;
        check("l3.rst.rdy", 32'(b3.Ready), 1);
        check("l3.rst.done", 32'(b3.Done), 0);
        check("l3.rst.out", b3.OutputData, 32'h0);
        @(negedge clk);
        rst3 = 1'b0;
        op3("l3.lw2", 1, 0, 2'd2, 32'h300, 32'h0, out);
        check("l3.lw2.out", out, 32'h12345678);

        // 256-byte depth wraps.
        op8(0, 1, 2'd2, 0, 32'h104, 32'hA5B6C7D8);
        check("d8.sw.done", 32'(b8.Done), 1);
        op8(1, 0, 2'd2, 0, 32'h004, 32'h0);
        check("d8.lw004", b8.OutputData, 32'hA5B6C7D8);
        op8(1, 0, 2'd1, 1, 32'h306, 32'h0);
        check("d8.lhu306", b8.OutputData, 32'h0000C7D8);
        op8(1, 0, 2'd0, 0, 32'hFFFF_FF05, 32'h0);
        check("d8.lb05", b8.OutputData, 32'hFFFFFFB6);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
